// File: rtl/sevenseg_scan_capture.sv
// Receive-side monitor for an 8-digit multiplexed seven-segment bus: debounces each
// selected {anode, segments} pair, decodes the glyph and assembles per-frame 32-bit values.
module sevenseg_scan_capture #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  anode_control,
  input  logic [6:0]  segments,
  output logic [31:0] captured_value,
  output logic [7:0]  digit_valid,
  output logic [31:0] frame_value,
  output logic        frame_valid,
  output logic        pattern_error,
  output logic        anode_error
);

  typedef enum logic [1:0] {IDLE, TRACK, HELD} state_t;

  localparam logic [7:0] STABLE_U = 8'(STABLE_CYCLES);

  // Inverse glyph table: {legal, nibble}; segment bit 6 = a, active low.
  function automatic logic [4:0] decode_glyph(input logic [6:0] seg);
    case (seg)
      7'b0000001: decode_glyph = {1'b1, 4'h0};
      7'b1001111: decode_glyph = {1'b1, 4'h1};
      7'b0010010: decode_glyph = {1'b1, 4'h2};
      7'b0000110: decode_glyph = {1'b1, 4'h3};
      7'b1001100: decode_glyph = {1'b1, 4'h4};
      7'b0100100: decode_glyph = {1'b1, 4'h5};
      7'b0100000: decode_glyph = {1'b1, 4'h6};
      7'b0001111: decode_glyph = {1'b1, 4'h7};
      7'b0000000: decode_glyph = {1'b1, 4'h8};
      7'b0000100: decode_glyph = {1'b1, 4'h9};
      7'b0001000: decode_glyph = {1'b1, 4'hA};
      7'b1100000: decode_glyph = {1'b1, 4'hB};
      7'b0110001: decode_glyph = {1'b1, 4'hC};
      7'b1000010: decode_glyph = {1'b1, 4'hD};
      7'b0110000: decode_glyph = {1'b1, 4'hE};
      7'b0111000: decode_glyph = {1'b1, 4'hF};
      default:    decode_glyph = 5'b0_0000;
    endcase
  endfunction

  state_t      state_r, state_n;
  logic [7:0]  count_r, count_n;
  logic [7:0]  anode_prev_r;
  logic [6:0]  seg_prev_r;

  logic        is_blank_s, is_select_s, same_s, accept_s;
  logic [2:0]  sel_idx_s;
  logic [7:0]  cand_s;
  logic [4:0]  glyph_s;
  logic [31:0] captured_next_s;
  logic [7:0]  dv_next_s;

  // Anode classification, stability tracking and next-state selection.
  always_comb begin
    is_blank_s  = (anode_control == 8'hFF);
    is_select_s = $onehot(~anode_control);
    same_s      = (anode_control == anode_prev_r) && (segments == seg_prev_r);
    sel_idx_s   = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (!anode_control[i]) begin
        sel_idx_s = i[2:0];
      end else begin
        sel_idx_s = sel_idx_s;
      end
    end
    state_n  = state_r;
    count_n  = count_r;
    accept_s = 1'b0;
    cand_s   = 8'd1;
    if (!is_select_s) begin
      state_n = IDLE;
      count_n = 8'd0;
    end else if (state_r == HELD && same_s) begin
      state_n = HELD;
      count_n = count_r;
    end else begin
      if (state_r == TRACK && same_s) begin
        cand_s = count_r + 8'd1;
      end else begin
        cand_s = 8'd1;
      end
      // Accept fires on the edge the count reaches the threshold, then saturates.
      if (cand_s >= STABLE_U) begin
        state_n  = HELD;
        count_n  = STABLE_U;
        accept_s = 1'b1;
      end else begin
        state_n  = TRACK;
        count_n  = cand_s;
      end
    end
  end

  // Shadow-register and digit-valid updates implied by an accept.
  always_comb begin
    glyph_s         = decode_glyph(segments);
    captured_next_s = captured_value;
    captured_next_s[{sel_idx_s, 2'b00} +: 4] = glyph_s[3:0];
    dv_next_s       = digit_valid | (8'd1 << sel_idx_s);
  end

  // State, history and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r        <= IDLE;
      count_r        <= 8'd0;
      anode_prev_r   <= 8'hFF;
      seg_prev_r     <= 7'd0;
      captured_value <= 32'd0;
      digit_valid    <= 8'd0;
      frame_value    <= 32'd0;
      frame_valid    <= 1'b0;
      pattern_error  <= 1'b0;
      anode_error    <= 1'b0;
    end else begin
      state_r       <= state_n;
      count_r       <= count_n;
      anode_prev_r  <= anode_control;
      seg_prev_r    <= segments;
      anode_error   <= !is_blank_s && !is_select_s;
      frame_valid   <= 1'b0;
      pattern_error <= 1'b0;
      if (accept_s) begin
        if (glyph_s[4]) begin
          captured_value <= captured_next_s;
          if (&dv_next_s) begin
            frame_value <= captured_next_s;
            frame_valid <= 1'b1;
            digit_valid <= 8'd0;
          end else begin
            digit_valid <= dv_next_s;
          end
        end else begin
          pattern_error <= 1'b1;
        end
      end else begin
        captured_value <= captured_value;
      end
    end
  end

endmodule

// File: tb/tb_sevenseg_scan_capture.sv
// Self-checking bench for sevenseg_scan_capture: directed scan sequences with a
// frame scoreboard popped on every frame_valid pulse.
module tb_sevenseg_scan_capture;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  anode_control;
  logic [6:0]  segments;
  logic [31:0] captured_value;
  logic [7:0]  digit_valid;
  logic [31:0] frame_value;
  logic        frame_valid;
  logic        pattern_error;
  logic        anode_error;

  sevenseg_scan_capture #(.STABLE_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .anode_control(anode_control), .segments(segments),
    .captured_value(captured_value), .digit_valid(digit_valid),
    .frame_value(frame_value), .frame_valid(frame_valid),
    .pattern_error(pattern_error), .anode_error(anode_error)
  );

  always #5 clk = ~clk;

  logic [6:0]  glyph [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                              7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                              7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                              7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

  int n_checks = 0;
  int n_pass   = 0;
  int n_frames = 0;
  int n_perr   = 0;
  int n_aerr   = 0;
  logic [31:0] sb [$];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // Output monitor: frame scoreboard plus pulse counters.
  always @(negedge clk) begin
    if (frame_valid === 1'b1) begin
      n_frames++;
      if (sb.size() == 0) check_val("sb_unexpected_frame", frame_value, 32'hxxxx_xxxx);
      else check_val("sb_frame_value", frame_value, sb.pop_front());
    end
    if (pattern_error === 1'b1) n_perr++;
    if (anode_error === 1'b1) n_aerr++;
  end

  task automatic drive(input logic [7:0] a, input logic [6:0] s, input int n);
    anode_control = a;
    segments      = s;
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] sel(input int i);
    logic [7:0] one;
    one = 8'd1 << i;
    return ~one;
  endfunction

  task automatic scan_frame(input logic [31:0] val);
    sb.push_back(val);
    for (int i = 0; i < 8; i++) drive(sel(i), glyph[val[4*i +: 4]], 4);
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_captured"}, captured_value, 32'd0);
    check_val({tag, "_dv"}, {24'd0, digit_valid}, 32'd0);
    check_val({tag, "_frame_value"}, frame_value, 32'd0);
    check_val({tag, "_flags"}, {29'd0, frame_valid, pattern_error, anode_error}, 32'd0);
  endtask

  int f0, p0, a0;
  logic [31:0] cap0;
  logic [7:0]  dv0;

  initial begin
    rst = 1'b1;
    anode_control = 8'hFF;
    segments = 7'd0;
    @(posedge clk); #1;
    for (int k = 0; k < 2; k++) begin
      anode_control = 8'($urandom);
      segments = 7'($urandom);
      @(posedge clk); #1;
    end
    rst = 1'b0;
    drive(8'hFF, 7'd0, 1);
    check_all_zero("reset");

    // Full frame showing 1..8.
    f0 = n_frames;
    scan_frame(32'h87654321);
    check_val("frame_pulse", {31'd0, frame_valid}, 32'd1);
    check_val("frame_value", frame_value, 32'h87654321);
    check_val("frame_dv_cleared", {24'd0, digit_valid}, 32'd0);
    check_val("frame_captured_kept", captured_value, 32'h87654321);
    drive(8'hFF, 7'd0, 1);
    check_val("frame_pulse_len", {31'd0, frame_valid}, 32'd0);
    check_val("frame_count", n_frames - f0, 32'd1);

    // Glitch: 3 cycles is short of the hold time.
    drive(sel(3), glyph[10], 3);
    drive(8'hFF, 7'd0, 2);
    check_val("glitch_nibble3", {28'd0, captured_value[15:12]}, 32'h4);
    check_val("glitch_dv", {24'd0, digit_valid}, 32'd0);
    drive(sel(3), glyph[10], 4);
    check_val("hold_nibble3", {28'd0, captured_value[15:12]}, 32'hA);
    check_val("hold_dv", {24'd0, digit_valid}, 32'h08);
    drive(8'hFF, 7'd0, 1);

    // Illegal glyph on display 2.
    p0 = n_perr;
    cap0 = captured_value;
    dv0 = digit_valid;
    drive(sel(2), 7'b1111110, 4);
    check_val("illegal_pulse_now", {31'd0, pattern_error}, 32'd1);
    drive(sel(2), 7'b1111110, 3);
    drive(8'hFF, 7'd0, 2);
    check_val("illegal_pulse_count", n_perr - p0, 32'd1);
    check_val("illegal_captured", captured_value, cap0);
    check_val("illegal_dv", {24'd0, digit_valid}, {24'd0, dv0});

    // Two anodes low together for 6 cycles.
    a0 = n_aerr;
    drive(8'b11111100, glyph[5], 6);
    check_val("multi_flag_now", {31'd0, anode_error}, 32'd1);
    drive(8'hFF, 7'd0, 3);
    check_val("multi_err_cycles", n_aerr - a0, 32'd6);
    check_val("multi_captured", captured_value, cap0);
    check_val("multi_dv", {24'd0, digit_valid}, {24'd0, dv0});

    // Partial frame then reset.
    for (int i = 0; i < 5; i++) drive(sel(i), glyph[i + 9], 4);
    check_val("partial_dv", {24'd0, digit_valid}, 32'h1F);
    rst = 1'b1;
    drive(8'hFF, 7'd0, 1);
    rst = 1'b0;
    check_all_zero("midreset");

    f0 = n_frames;
    scan_frame(32'hFFFFFFFF);
    drive(8'hFF, 7'd0, 1);
    check_val("allf_frame_value", frame_value, 32'hFFFFFFFF);
    check_val("allf_count", n_frames - f0, 32'd1);

    // Overwrite display 0 before the frame completes.
    f0 = n_frames;
    sb.push_back(32'h76543219);
    drive(sel(0), glyph[4], 4);
    check_val("ovw_first", {28'd0, captured_value[3:0]}, 32'h4);
    drive(sel(0), glyph[9], 4);
    check_val("ovw_second", {28'd0, captured_value[3:0]}, 32'h9);
    check_val("ovw_dv", {24'd0, digit_valid}, 32'h01);
    for (int i = 1; i < 8; i++) drive(sel(i), glyph[i], 4);
    drive(8'hFF, 7'd0, 2);
    check_val("ovw_frame_value", frame_value, 32'h76543219);
    check_val("ovw_frame_count", n_frames - f0, 32'd1);
    check_val("sb_drained", sb.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
